// File: rtl/mm1_mem_req.sv
// MM1 memory-request stage: drives the data-side SRAM-like request bus, builds strobes/store data,
// flags misaligned accesses and drops responses that belong to flushed instructions.
module mm1_mem_req #(
  parameter int MAX_OUTST = 2,
  parameter int CNT_W     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mm1_valid,
  input  logic        mm1_mm_re,
  input  logic        mm1_mm_we,
  input  logic [1:0]  mm1_mm_sz,
  input  logic [31:0] mm1_mm_addr,
  input  logic [31:0] mm1_mm_wdata,
  input  logic        flush,
  input  logic        mm2_allowin,
  output logic        mm1_allowin,
  output logic        mm1_to_mm2_vld,
  output logic        mm1_ale,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic        mm2_resp_vld,
  output logic [31:0] mm2_resp_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, DONE, CANCEL} state_t;

  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] lo);
    case (sz)
      2'd0:    return 1'b0;
      2'd1:    return lo[0];
      default: return lo != 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] strobe(input logic we, input logic [1:0] sz, input logic [1:0] lo);
    if (!we) return 4'b0000;
    case (sz)
      2'd0:    return 4'b0001 << lo;
      2'd1:    return lo[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] replicate(input logic [1:0] sz, input logic [31:0] wd);
    case (sz)
      2'd0:    return {4{wd[7:0]}};
      2'd1:    return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  state_t           state;
  logic [CNT_W-1:0] outst_cnt;
  logic [CNT_W-1:0] discard_cnt;
  logic [CNT_W-1:0] outst_nxt;
  logic [CNT_W-1:0] discard_nxt;

  // request fields captured on issue so the bus stays stable while waiting for addr_ok
  logic        wr_p1;
  logic [1:0]  size_p1;
  logic [3:0]  wstrb_p1;
  logic [31:0] addr_p1;
  logic [31:0] wdata_p1;

  logic        mem_op;
  logic        issue;
  logic        in_req;
  logic        acc;
  logic        ready_go;
  logic        drop;
  logic [1:0]  size_p0;

  assign mem_op   = mm1_valid & (mm1_mm_re | mm1_mm_we);
  assign mm1_ale  = mem_op & misaligned(mm1_mm_sz, mm1_mm_addr[1:0]);
  assign issue    = (state == IDLE) & mem_op & ~mm1_ale & ~flush &
                    (outst_cnt < CNT_W'(MAX_OUTST));
  assign in_req   = issue | (state == REQ);
  assign data_req = in_req | (state == CANCEL);
  assign acc      = data_req & data_addr_ok;
  assign ready_go = ~mem_op | mm1_ale | (state == DONE) | (in_req & data_addr_ok);
  assign size_p0  = (mm1_mm_sz == 2'd3) ? 2'd2 : mm1_mm_sz;

  assign mm1_to_mm2_vld = mm1_valid & ready_go & ~flush & (state != CANCEL);
  assign mm1_allowin    = (state != CANCEL) & (~mm1_valid | (ready_go & mm2_allowin));

  assign data_wr    = (state == IDLE) ? mm1_mm_we : wr_p1;
  assign data_size  = (state == IDLE) ? size_p0 : size_p1;
  assign data_wstrb = (state == IDLE) ? strobe(mm1_mm_we, mm1_mm_sz, mm1_mm_addr[1:0]) : wstrb_p1;
  assign data_addr  = (state == IDLE) ? mm1_mm_addr : addr_p1;
  assign data_wdata = (state == IDLE) ? replicate(mm1_mm_sz, mm1_mm_wdata) : wdata_p1;

  assign drop           = data_data_ok & (discard_cnt != '0);
  assign mm2_resp_vld   = data_data_ok & (discard_cnt == '0);
  assign mm2_resp_rdata = data_rdata;

  // a flush turns everything still in flight after this cycle into responses to discard
  always_comb begin
    outst_nxt = outst_cnt;
    if (acc && !data_data_ok)
      outst_nxt = outst_cnt + 1'b1;
    else if (!acc && data_data_ok)
      outst_nxt = outst_cnt - 1'b1;
    discard_nxt = discard_cnt;
    if (flush)
      discard_nxt = outst_nxt;
    else if ((state == CANCEL) && acc && !drop)
      discard_nxt = discard_cnt + 1'b1;
    else if (!((state == CANCEL) && acc) && drop)
      discard_nxt = discard_cnt - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      outst_cnt   <= '0;
      discard_cnt <= '0;
    end else begin
      outst_cnt   <= outst_nxt;
      discard_cnt <= discard_nxt;
      case (state)
        IDLE: if (issue) state <= acc ? (mm2_allowin ? IDLE : DONE) : REQ;
        REQ: begin
          if (flush)    state <= acc ? IDLE : CANCEL;
          else if (acc) state <= mm2_allowin ? IDLE : DONE;
        end
        DONE:   if (flush || mm2_allowin) state <= IDLE;
        CANCEL: if (acc) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // ---- p0 -> p1: capture request fields ----
  always_ff @(posedge clk) begin
    if (issue) begin
      wr_p1    <= mm1_mm_we;
      size_p1  <= size_p0;
      wstrb_p1 <= strobe(mm1_mm_we, mm1_mm_sz, mm1_mm_addr[1:0]);
      addr_p1  <= mm1_mm_addr;
      wdata_p1 <= replicate(mm1_mm_sz, mm1_mm_wdata);
    end
  end

endmodule
